// File: rtl/dac_tx_sched.sv
// dac_tx_sched: header transmit scheduler for the DAC path.
// Turns a transmit request into a train of header bursts aligned to a
// free-running period counter, with dac_valid flow control on header beats.
// Optional build macro DAC_TX_SCHED_STATS_EN enables the 32-bit saturating
// stat_hdrs / stat_drops counters; otherwise both are tied to 0.
//
// state  | meaning
// IDLE   | no train; waiting for a request (or continuous mode)
// WAIT   | train active, waiting for the next period tic
// HDR    | header burst in progress, beats advance on dac_valid
// DONE   | train complete, one-cycle done pulse
module dac_tx_sched #(
  parameter int PD_W  = 24,
  parameter int QTY_W = 16,
  parameter int LEN_W = 6
) (
  input  logic             dac_clk,
  input  logic             dac_rstn,
  input  logic             dac_valid,
  input  logic [PD_W-1:0]  cfg_pd_min1,
  input  logic [QTY_W-1:0] cfg_qty_min1,
  input  logic [LEN_W-1:0] cfg_len_min1,
  input  logic             cfg_tx_unsync,
  input  logic             cfg_tx_always,
  input  logic             sync_req,
  input  logic             unsync_req,
  input  logic             abort,
  output logic             pd_tic,
  output logic             hdr_tx,
  output logic             hdr_first,
  output logic             hdr_vld,
  output logic             txing,
  output logic             done,
  output logic             req_drop,
  output logic [31:0]      stat_hdrs,
  output logic [31:0]      stat_drops
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HDR  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_nxt;
  logic [PD_W-1:0]  pcnt;
  logic             pd_wrap;
  logic             req, req_d, req_edge_q;
  logic [QTY_W-1:0] hcnt_q, hcnt_nxt, qty_l, qty_nxt;
  logic [LEN_W-1:0] bcnt_q, bcnt_nxt, len_l, len_nxt;
  logic             first_q, first_nxt;
  logic             always_l, always_nxt;
  logic             start, drop, hdr_tx_nxt;

  // >= keeps the counter bounded if the period shrinks while running
  assign pd_wrap = (pcnt >= cfg_pd_min1);
  assign req     = cfg_tx_unsync ? unsync_req : sync_req;
  assign start   = req_edge_q | cfg_tx_always;
  assign drop    = req_edge_q & (state_q != S_IDLE);

  // Free-running period counter and registered wrap tic
  always_ff @(posedge dac_clk or negedge dac_rstn) begin
    if (!dac_rstn) begin
      pcnt   <= '0;
      pd_tic <= 1'b0;
    end else begin
      pcnt   <= pd_wrap ? '0 : pcnt + 1'b1;
      pd_tic <= pd_wrap;
    end
  end

  // Request source delay and registered rising-edge detect
  always_ff @(posedge dac_clk or negedge dac_rstn) begin
    if (!dac_rstn) begin
      req_d      <= 1'b0;
      req_edge_q <= 1'b0;
    end else begin
      req_d      <= req;
      req_edge_q <= req & ~req_d;
    end
  end

  // Next-state and train bookkeeping
  always_comb begin
    state_nxt  = state_q;
    hcnt_nxt   = hcnt_q;
    bcnt_nxt   = bcnt_q;
    first_nxt  = first_q;
    qty_nxt    = qty_l;
    len_nxt    = len_l;
    always_nxt = always_l;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          qty_nxt    = cfg_qty_min1;
          len_nxt    = cfg_len_min1;
          always_nxt = cfg_tx_always;
          hcnt_nxt   = '0;
          bcnt_nxt   = '0;
          first_nxt  = 1'b1;
          state_nxt  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (pd_tic) state_nxt = S_HDR;
      end
      S_HDR: begin
        if (dac_valid) begin
          if (bcnt_q == len_l) begin
            // a continuous train ends as soon as tx_always is seen low
            if (!cfg_tx_always && (always_l || (hcnt_q == qty_l))) begin
              state_nxt = S_DONE;
            end else begin
              hcnt_nxt  = hcnt_q + 1'b1;
              bcnt_nxt  = '0;
              first_nxt = 1'b0;
              state_nxt = S_WAIT;
            end
          end else begin
            bcnt_nxt = bcnt_q + 1'b1;
          end
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  assign hdr_tx_nxt = (state_q == S_WAIT) && (state_nxt == S_HDR);

  // State, train registers and outputs decoded from the next state
  always_ff @(posedge dac_clk or negedge dac_rstn) begin
    if (!dac_rstn) begin
      state_q   <= S_IDLE;
      hcnt_q    <= '0;
      bcnt_q    <= '0;
      first_q   <= 1'b0;
      qty_l     <= '0;
      len_l     <= '0;
      always_l  <= 1'b0;
      hdr_tx    <= 1'b0;
      hdr_first <= 1'b0;
      hdr_vld   <= 1'b0;
      txing     <= 1'b0;
      done      <= 1'b0;
      req_drop  <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      hcnt_q    <= hcnt_nxt;
      bcnt_q    <= bcnt_nxt;
      first_q   <= first_nxt;
      qty_l     <= qty_nxt;
      len_l     <= len_nxt;
      always_l  <= always_nxt;
      hdr_tx    <= hdr_tx_nxt;
      hdr_first <= (state_nxt == S_HDR) && first_nxt;
      hdr_vld   <= (state_nxt == S_HDR);
      txing     <= (state_nxt != S_IDLE);
      done      <= (state_nxt == S_DONE);
      req_drop  <= req_drop | drop;
    end
  end

`ifdef DAC_TX_SCHED_STATS_EN
  // Saturating header-start and dropped-request counters
  always_ff @(posedge dac_clk or negedge dac_rstn) begin
    if (!dac_rstn) begin
      stat_hdrs  <= '0;
      stat_drops <= '0;
    end else begin
      if (hdr_tx_nxt && (stat_hdrs != 32'hFFFF_FFFF)) stat_hdrs <= stat_hdrs + 32'd1;
      if (drop && (stat_drops != 32'hFFFF_FFFF)) stat_drops <= stat_drops + 32'd1;
    end
  end
`else
  assign stat_hdrs  = '0;
  assign stat_drops = '0;
`endif

endmodule
